nibble_pack_arbiter: RTL and testbench

- Shares one nibble-pack datapath between NUM_REQ requesters. Each requester supplies a low nibble a and a high nibble b. The block emits the packed byte {b, a} on a single registered valid/ready output.
- Round-robin arbitration with packet lock: once a requester wins, it keeps the datapath until it sends a beat with last=1.
- Sits between per-lane nibble producers and a downstream byte consumer.

---
 rtl/nibble_pack_arbiter_if.sv | 28 ++
 rtl/nibble_pack_arbiter.sv | 149 ++++++++++++++
 tb/tb_nibble_pack_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/nibble_pack_arbiter_if.sv
// Bundle of the requester-side nibble beats and the downstream packed-byte stream.
// The slave modport is the arbiter's view; master is the environment's view.
interface nibble_pack_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int NIBBLE_W = 4,
    parameter int ID_W     = 2
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*NIBBLE_W-1:0] req_a;
    logic [NUM_REQ*NIBBLE_W-1:0] req_b;
    logic [NUM_REQ-1:0]          req_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [2*NIBBLE_W-1:0]       out;
    logic [ID_W-1:0]             out_id;
    logic                        out_last;

    modport master (
        output req_valid, req_a, req_b, req_last, out_ready,
        input  req_ready, out_valid, out, out_id, out_last
    );

    modport slave (
        input  req_valid, req_a, req_b, req_last, out_ready,
        output req_ready, out_valid, out, out_id, out_last
    );
endinterface

// File: rtl/nibble_pack_arbiter.sv
// Round-robin arbiter with packet lock feeding a single registered slot that packs
// {b, a} nibbles from the granted requester into one byte.
module nibble_pack_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NIBBLE_W = 4,
    parameter int ID_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_pack_arbiter_if.slave  bus
);
    localparam int OUT_W = 2 * NIBBLE_W;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        ST_ARB = 1'b0,
        ST_OWN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [ID_W-1:0]    out_id_q, out_id_d;
    logic               out_last_q, out_last_d;

    logic               load_s;
    logic               found_s;
    logic [IDX_W-1:0]   cand_s;
    logic [IDX_W-1:0]   winner_s;
    logic [IDX_W-1:0]   grant_id_s;
    logic               grant_vld_s;
    logic [IDX_W-1:0]   grant_inc_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic               accept_s;

    logic [NIBBLE_W-1:0] a_arr_s [NUM_REQ];
    logic [NIBBLE_W-1:0] b_arr_s [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr_s[g] = bus.req_a[g*NIBBLE_W +: NIBBLE_W];
        assign b_arr_s[g] = bus.req_b[g*NIBBLE_W +: NIBBLE_W];
    end

    // The slot may take a new byte when it is empty or being drained this cycle.
    assign load_s = !out_valid_q || bus.out_ready;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        found_s  = 1'b0;
        winner_s = ptr_q;
        cand_s   = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found_s && bus.req_valid[cand_s]) begin
                found_s  = 1'b1;
                winner_s = cand_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Output process of the FSM: the locked owner bypasses the search entirely.
    always_comb begin
        grant_id_s  = winner_s;
        grant_vld_s = 1'b0;
        req_ready_s = {NUM_REQ{1'b0}};
        case (state_q)
            ST_ARB: begin
                grant_id_s  = winner_s;
                grant_vld_s = found_s;
            end
            ST_OWN: begin
                grant_id_s  = owner_q;
                grant_vld_s = 1'b1;
            end
            default: begin
                grant_id_s  = winner_s;
                grant_vld_s = 1'b0;
            end
        endcase
        if (!rst && load_s && grant_vld_s) begin
            req_ready_s[grant_id_s] = 1'b1;
        end else begin
            req_ready_s = {NUM_REQ{1'b0}};
        end
    end

    assign accept_s    = |(req_ready_s & bus.req_valid);
    assign grant_inc_s = (grant_id_s == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}}
                                                             : grant_id_s + IDX_W'(1);

    // Next-state process: load the slot on accept, drop valid on an idle drain.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        out_id_d    = out_id_q;
        out_last_d  = out_last_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_d       = {b_arr_s[grant_id_s], a_arr_s[grant_id_s]};
            out_id_d    = ID_W'(grant_id_s);
            out_last_d  = bus.req_last[grant_id_s];
            if (bus.req_last[grant_id_s]) begin
                state_d = ST_ARB;
                ptr_d   = grant_inc_s;
            end else begin
                state_d = ST_OWN;
                owner_d = grant_id_s;
            end
        end else if (load_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State register; reset abandons any locked packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARB;
            ptr_q       <= {IDX_W{1'b0}};
            owner_q     <= {IDX_W{1'b0}};
            out_valid_q <= 1'b0;
            out_q       <= {OUT_W{1'b0}};
            out_id_q    <= {ID_W{1'b0}};
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_id_q    <= out_id_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_nibble_pack_arbiter.sv
// Directed bench for nibble_pack_arbiter: reset, round-robin, packet lock,
// backpressure, owner gap and mid-packet reset, checked with immediate assertions.
module tb_nibble_pack_arbiter;
    localparam int NR = 4;
    localparam int NW = 4;
    localparam int IW = 2;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    nibble_pack_arbiter_if #(.NUM_REQ(NR), .NIBBLE_W(NW), .ID_W(IW)) bus ();

    nibble_pack_arbiter #(.NUM_REQ(NR), .NIBBLE_W(NW), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] a,
                           input logic [3:0] b, input logic l);
        bus.req_valid[i]        = v;
        bus.req_a[i*NW +: NW]   = a;
        bus.req_b[i*NW +: NW]   = b;
        bus.req_last[i]         = l;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] o, input logic [1:0] id,
                           input logic last);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_out"},   32'(bus.out),       32'(o));
        chk({tag, "_id"},    32'(bus.out_id),    32'(id));
        chk({tag, "_last"},  32'(bus.out_last),  32'(last));
    endtask

    logic [7:0] rr_out [5];
    logic [1:0] rr_id  [5];

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rr_out = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        rr_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset with everyone requesting.
        rst = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 4'(i), 4'hA, 1'b1);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_ready", 32'(bus.req_ready), 32'h0);
            chk("rst_valid", 32'(bus.out_valid), 32'h0);
            chk("rst_out",   32'(bus.out),       32'h0);
            chk("rst_id",    32'(bus.out_id),    32'h0);
            chk("rst_last",  32'(bus.out_last),  32'h0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'h1);

        // Single-beat round robin.
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out("rr", rr_out[k], rr_id[k], 1'b1);
        end
        for (int i = 0; i < NR; i++) bus.req_valid[i] = 1'b0;
        tick();
        chk("rr_drain_valid", 32'(bus.out_valid), 32'h0);

        // Backpressure: ptr is now 1, so A1 comes out first.
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 4'(i), 4'hA, 1'b1);
        tick();
        chk_out("bp_first", 8'hA1, 2'd1, 1'b1);
        bus.out_ready = 1'b0;
        #1;
        chk("bp_ready0", 32'(bus.req_ready), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out("bp_hold", 8'hA1, 2'd1, 1'b1);
            chk("bp_ready", 32'(bus.req_ready), 32'h0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.req_ready), 32'h4);
        tick();
        chk_out("bp_next", 8'hA2, 2'd2, 1'b1);
        for (int i = 0; i < NR; i++) bus.req_valid[i] = 1'b0;
        tick();
        chk("bp_drain_valid", 32'(bus.out_valid), 32'h0);

        // Move ptr from 3 to 2 with a lone beat from requester 1.
        set_req(1, 1'b1, 4'h7, 4'hC, 1'b1);
        tick();
        chk_out("align", 8'hC7, 2'd1, 1'b1);

        // Packet lock: requester 2 owns for three beats while 0 and 3 wait.
        set_req(1, 1'b0, 4'h0, 4'h0, 1'b0);
        set_req(0, 1'b1, 4'h0, 4'hE, 1'b1);
        set_req(3, 1'b1, 4'h3, 4'hE, 1'b1);
        set_req(2, 1'b1, 4'h1, 4'h5, 1'b0);
        #1;
        chk("lock_ready0", 32'(bus.req_ready), 32'h4);
        tick();
        chk_out("lock_b1", 8'h51, 2'd2, 1'b0);
        set_req(2, 1'b1, 4'h2, 4'h5, 1'b0);
        #1;
        chk("lock_ready1", 32'(bus.req_ready), 32'h4);
        tick();
        chk_out("lock_b2", 8'h52, 2'd2, 1'b0);
        set_req(2, 1'b1, 4'h3, 4'h5, 1'b1);
        tick();
        chk_out("lock_b3", 8'h53, 2'd2, 1'b1);
        bus.req_valid[2] = 1'b0;
        tick();
        chk_out("lock_next3", 8'hE3, 2'd3, 1'b1);
        tick();
        chk_out("lock_next0", 8'hE0, 2'd0, 1'b1);
        for (int i = 0; i < NR; i++) bus.req_valid[i] = 1'b0;
        tick();
        chk("lock_drain_valid", 32'(bus.out_valid), 32'h0);

        // Owner gap: ptr is 1; requester 1 locks, then idles for 4 cycles.
        set_req(1, 1'b1, 4'h1, 4'h9, 1'b0);
        set_req(0, 1'b1, 4'h0, 4'hB, 1'b1);
        tick();
        chk_out("gap_b1", 8'h91, 2'd1, 1'b0);
        bus.req_valid[1] = 1'b0;
        #1;
        chk("gap_ready_start", 32'(bus.req_ready), 32'h2);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("gap_valid", 32'(bus.out_valid), 32'h0);
            chk("gap_ready", 32'(bus.req_ready), 32'h2);
        end
        set_req(1, 1'b1, 4'h2, 4'h9, 1'b1);
        tick();
        chk_out("gap_b2", 8'h92, 2'd1, 1'b1);
        bus.req_valid[1] = 1'b0;
        tick();
        chk_out("gap_then0", 8'hB0, 2'd0, 1'b1);
        for (int i = 0; i < NR; i++) bus.req_valid[i] = 1'b0;

        // Reset mid-packet: requester 1 holds the lock when rst hits.
        set_req(1, 1'b1, 4'h4, 4'hD, 1'b0);
        tick();
        chk_out("mid_b1", 8'hD4, 2'd1, 1'b0);
        rst = 1'b1;
        set_req(0, 1'b1, 4'h5, 4'h6, 1'b1);
        #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_out",   32'(bus.out),       32'h0);
        rst = 1'b0;
        #1;
        chk("mid_post_ready", 32'(bus.req_ready), 32'h1);
        tick();
        chk_out("mid_first", 8'h65, 2'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
